// File: rtl/state_log_pkg.sv
// Shared sizing and log-entry format for the debug-state history logger.
package state_log_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned STATE_W = 16;
  localparam int unsigned SRC_W   = $clog2(NUM_SRC);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned LOST_W  = 8;

  typedef struct packed {
    logic [SRC_W-1:0]   src_id;
    logic [STATE_W-1:0] state;
  } log_entry_t;

endpackage

// File: rtl/state_log_arbiter_rr.sv
// Round-robin grant: picks the first requester at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt_c,
  output logic [$clog2(N)-1:0] o_gnt_idx_c,
  output logic                 o_gnt_vld_c
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_gnt_c     = '0;
    o_gnt_idx_c = '0;
    o_gnt_vld_c = 1'b0;
    w_idx       = '0;
    w_found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = IW'((32'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_gnt_c[w_idx] = 1'b1;
        o_gnt_idx_c    = w_idx;
        o_gnt_vld_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/state_log_arbiter.sv
// Captures per-source debug-state transitions and funnels them through a
// round-robin arbiter into one shared history FIFO drained by the host.
module state_log_arbiter #(
  parameter int unsigned NUM_SRC = state_log_pkg::NUM_SRC,
  parameter int unsigned DEPTH   = state_log_pkg::DEPTH
) (
  input  logic                          iClk,
  input  logic                          iRst_n,
  input  logic                          iClear,
  input  logic [16*NUM_SRC-1:0]         iDbgSt,
  input  logic                          iRdReq,
  output logic [16+$clog2(NUM_SRC)-1:0] oRdData,
  output logic                          oRdValid,
  output logic                          oEmpty,
  output logic                          oFull,
  output logic [$clog2(DEPTH):0]        oCount,
  output logic [7:0]                    oLostCnt
);

  import state_log_pkg::*;

  localparam int unsigned SW       = $clog2(NUM_SRC);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned EW       = STATE_W + SW;
  localparam int unsigned LOST_MAX = 255;

  logic [STATE_W-1:0] r_last     [NUM_SRC];
  logic [STATE_W-1:0] r_pend_val [NUM_SRC];
  logic [NUM_SRC-1:0] r_pending;
  logic [SW-1:0]      r_ptr;
  logic [EW-1:0]      r_mem      [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;

  logic [NUM_SRC-1:0] w_changed;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  logic [NUM_SRC-1:0] w_lost;
  logic [SW-1:0]      w_gnt_idx;
  logic               w_gnt_vld;
  logic               w_wr;
  logic               w_rd;
  logic               w_clr;
  logic [CW-1:0]      w_count_nxt;
  logic [8:0]         w_lost_sum;

  // Reset and clear share one path: both resample the inputs as the new baseline.
  assign w_clr = !iRst_n || iClear;

  always_comb begin
    w_changed = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_changed[k] = iDbgSt[k*STATE_W +: STATE_W] != r_last[k];
    end
  end

  // No grant while full, so pending values stay parked in their slots.
  assign w_req = oFull ? '0 : r_pending;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr_arbiter (
    .i_req       (w_req),
    .i_ptr       (r_ptr),
    .o_gnt_c     (w_gnt),
    .o_gnt_idx_c (w_gnt_idx),
    .o_gnt_vld_c (w_gnt_vld)
  );

  assign w_wr   = w_gnt_vld;
  assign w_rd   = iRdReq && !oEmpty;
  assign w_lost = w_changed & r_pending & ~w_gnt;

  always_comb begin
    w_lost_sum = {1'b0, oLostCnt};
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_lost_sum = w_lost_sum + 9'(w_lost[k]);
    end
  end

  always_comb begin
    w_count_nxt = oCount;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = oCount + CW'(1);
      2'b01:   w_count_nxt = oCount - CW'(1);
      default: w_count_nxt = oCount;
    endcase
  end

  // A change in the grant cycle re-arms pending with the newer value.
  always_ff @(posedge iClk) begin
    if (w_clr) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        r_last[k]     <= iDbgSt[k*STATE_W +: STATE_W];
        r_pend_val[k] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (w_changed[k]) begin
          r_last[k]     <= iDbgSt[k*STATE_W +: STATE_W];
          r_pend_val[k] <= iDbgSt[k*STATE_W +: STATE_W];
        end
      end
      r_pending <= w_changed | (r_pending & ~w_gnt);
    end
  end

  always_ff @(posedge iClk) begin
    if (w_clr) begin
      r_ptr    <= '0;
      oLostCnt <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_ptr <= (w_gnt_idx == SW'(NUM_SRC - 1)) ? '0 : w_gnt_idx + SW'(1);
      end
      oLostCnt <= (w_lost_sum > 9'(LOST_MAX)) ? 8'hFF : w_lost_sum[7:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      oCount   <= '0;
      oEmpty   <= 1'b1;
      oFull    <= 1'b0;
      oRdValid <= 1'b0;
      oRdData  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        oRdData  <= r_mem[r_rd_ptr];
      end
      oCount   <= w_count_nxt;
      oEmpty   <= w_count_nxt == '0;
      oFull    <= w_count_nxt == CW'(DEPTH);
      oRdValid <= w_rd;
    end
  end

  always_ff @(posedge iClk) begin
    if (w_wr && !w_clr) begin
      r_mem[r_wr_ptr] <= {w_gnt_idx, r_pend_val[w_gnt_idx]};
    end
  end

endmodule

// File: doc/state_log_arbiter.md
STATE_LOG_ARBITER -- requirements
Module: state_log_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of 16-bit debug-state sources.
REQ-002 Parameter DEPTH, default 16 (power of 2), SHALL set the number of entries in the shared history FIFO.
REQ-003 iClk  in  1  SHALL be the clock; all logic is rising-edge.
REQ-004 iRst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 iClear  in  1  SHALL be a synchronous log clear, active-high.
REQ-006 iDbgSt  in  16*NUM_SRC  SHALL carry the debug states; source k occupies bits [16k+15:16k].
REQ-007 iRdReq  in  1  SHALL be the host pop request, one entry per asserted cycle.
REQ-008 oRdData  out  16+log2(NUM_SRC)  SHALL be the popped entry, formatted {src_id, state}.
REQ-009 oRdValid  out  1  SHALL be a one-cycle pulse qualifying oRdData.
REQ-010 oEmpty / oFull  out  1 each  SHALL be the registered FIFO status flags.
REQ-011 oCount  out  log2(DEPTH)+1  SHALL give the FIFO occupancy.
REQ-012 oLostCnt  out  8  SHALL count overwritten transitions, saturating.

Function
REQ-013 Each source SHALL have a last-value register; iDbgSt[k] != last[k] at an edge SHALL load last[k] and set pending[k] with pend_val[k] = iDbgSt[k].
REQ-014 A change on a source whose pending[k] is already set and not granted that cycle SHALL overwrite pend_val[k] and increment oLostCnt, which saturates at 255.
REQ-015 A round-robin arbiter SHALL grant at most one pending source per cycle when the FIFO is not full, searching from ptr upward and wrapping.
REQ-016 After a grant to source g, ptr SHALL become (g+1) mod NUM_SRC; with no grant, ptr SHALL hold.
REQ-017 A granted entry SHALL be written to the FIFO at the same edge that clears pending[g].
REQ-018 If the same source changes in its grant cycle, pending[g] SHALL remain set with the new value and no loss SHALL be counted.
REQ-019 Latency: a change sampled at edge N on an idle, non-full system SHALL be in the FIFO at edge N+1, with oEmpty low after N+1.
REQ-020 When the FIFO is full, no grant SHALL occur; pending entries SHALL be held and losses counted per REQ-014.
REQ-021 A write while full SHALL never occur, even with a read in the same cycle.
REQ-022 A read SHALL occur when iRdReq=1 and oEmpty=0; oRdData and oRdValid SHALL be registered and appear at the next edge.
REQ-023 iRdReq while empty SHALL be ignored, with oRdValid=0.
REQ-024 A simultaneous read and write when not full SHALL leave oCount unchanged.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH; oFull SHALL equal (oCount==DEPTH) and oEmpty SHALL equal (oCount==0).
REQ-026 iClear SHALL empty the FIFO, clear pending[], ptr, oLostCnt and oRdValid, and load last[k] with iDbgSt[k], so no entry is generated by the clear itself.
REQ-027 iClear SHALL take priority over any simultaneous grant or read.

Reset
REQ-028 At an edge with iRst_n=0, the block SHALL take the iClear state: last[k]=iDbgSt[k], pending=0, ptr=0, oCount=0, oEmpty=1, oFull=0, oLostCnt=0, oRdValid=0, oRdData=0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents and pending entries within that same edge.

Structure
REQ-030 Package state_log_pkg SHALL hold NUM_SRC, DEPTH, SRC_W, CNT_W and the log-entry typedef {src_id, state}.
REQ-031 The round-robin grant logic SHALL be a sub-module, rr_arbiter (inputs req, ptr; outputs gnt one-hot, gnt_idx, gnt_vld).
REQ-032 FIFO storage SHALL be an inferred register array inside the top module.

Verification
REQ-033 Reset with iDbgSt={4'hAAAA..}, hold inputs for 10 cycles -> oEmpty=1, oCount=0, no entries.
REQ-034 Src0 steps 0x0001->0x0002 at edge N -> at edge N+1 oCount=1; pulse iRdReq -> oRdData={0,0x0002} with oRdValid at the next edge.
REQ-035 All 4 sources change in the same cycle with ptr=0 -> FIFO order src0, src1, src2, src3 on consecutive cycles; the next lone src1 change is granted with ptr=0.
REQ-036 Fill to 16 entries, then src2 changes 3 times while full -> oFull=1, oLostCnt=2; after one read, src2's last value is written.
REQ-037 Assert iClear with 5 entries and 2 pending while iDbgSt differs from last -> oCount=0, oLostCnt=0, no entry is generated next cycle.
REQ-038 Continuous read+write for 40 cycles -> pointers wrap, oCount stays constant, and data order is preserved.
